// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed common-anode 7-segment driver with shadow registers and an anti-ghost guard interval
module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           scan_idx
);
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_blank, sh_dp;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    last, guard, off;
  logic [3:0]              nib;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'b0000001;
      4'h1: dec = 7'b1001111;
      4'h2: dec = 7'b0010010;
      4'h3: dec = 7'b0000110;
      4'h4: dec = 7'b1001100;
      4'h5: dec = 7'b0100100;
      4'h6: dec = 7'b0100000;
      4'h7: dec = 7'b0001111;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0000100;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b1100000;
      4'hC: dec = 7'b0110001;
      4'hD: dec = 7'b1000010;
      4'hE: dec = 7'b0110000;
      default: dec = 7'b0111000;
    endcase
  endfunction
  always_comb begin
    last  = cnt == CW'(REFRESH_DIV - 1);
    guard = cnt < CW'(GUARD_CYCLES);
    nib   = sh_data[4*idx +: 4];
    off   = guard || sh_blank[idx];
  end
  // outputs are derived from the pre-edge cnt/idx/shadow, giving one cycle of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data  <= '0;
      sh_blank <= '1;
      sh_dp    <= '0;
      cnt      <= '0;
      idx      <= '0;
      seg      <= 7'h7F;
      dp       <= 1'b1;
      an       <= '1;
      scan_idx <= '0;
    end else begin
      if (load) begin
        sh_data  <= data_in;
        sh_blank <= blank_in;
        sh_dp    <= dp_in;
      end
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
      an       <= guard ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg      <= off ? 7'h7F : dec(nib);
      dp       <= off || !sh_dp[idx];
      scan_idx <= idx;
    end
  end
endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: directed self-checking bench for seg7_mux_driver (4 digits, 8-cycle slots, 2-cycle guard)
module tb_seg7_mux_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  scan_idx;
  int          assertions = 0;
  int          failures = 0;
  logic [6:0]  dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seg7_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .blank_in(blank_in), .dp_in(dp_in),
    .load(load), .seg(seg), .dp(dp), .an(an), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assertions++;
    if ($countones(~an) > 1) begin
      failures++;
      $display("FAIL one_hot_an time=%0t an=%b required at most one zero", $time, an);
    end
  end

  // resets, then releases reset with a single load pulse; returns at sample t=0
  task automatic start(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    rst = 1'b1;
    load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load = 1'b1;
    data_in = d;
    blank_in = b;
    dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    load = 1'b1;
    data_in = 16'h3210;
    blank_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assertions++;
      if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'b1111 || scan_idx !== 2'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got seg=%b dp=%b an=%b idx=%0d required 1111111 1 1111 0", i, seg, dp, an, scan_idx);
      end
    end
    rst = 1'b0;
    load = 1'b0;
    repeat (3) @(negedge clk);
    assertions++;
    if (an !== 4'b1110 || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("FAIL reset_over_load got an=%b seg=%b dp=%b required 1110 1111111 1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    int k;
    logic g;
    start(16'h3210, 4'b0000, 4'b0000);
    data_in = 16'hFFFF;
    for (int t = 0; t < 40; t++) begin
      k = (t / 8) % 4;
      g = (t % 8) < 2;
      assertions += 4;
      if (an !== (g ? 4'b1111 : ~(4'b0001 << k))) begin
        failures++;
        $display("FAIL scan_an t=%0d got %b required %b", t, an, g ? 4'b1111 : ~(4'b0001 << k));
      end
      if (seg !== (g ? 7'h7F : dec_tab[k])) begin
        failures++;
        $display("FAIL scan_seg t=%0d got %b required %b", t, seg, g ? 7'h7F : dec_tab[k]);
      end
      if (dp !== 1'b1) begin
        failures++;
        $display("FAIL scan_dp t=%0d got %b required 1", t, dp);
      end
      if (scan_idx !== 2'(k)) begin
        failures++;
        $display("FAIL scan_idx t=%0d got %0d required %0d", t, scan_idx, k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_decode();
    logic [15:0] words [3] = '{16'hFEDC, 16'hBA98, 16'h7654};
    logic [15:0] w;
    logic [3:0] n;
    int k;
    for (int i = 0; i < 3; i++) begin
      w = words[i];
      start(w, 4'b0000, 4'b0000);
      for (int t = 0; t < 32; t++) begin
        k = t / 8;
        n = w[4*k +: 4];
        if ((t % 8) >= 2) begin
          assertions++;
          if (seg !== dec_tab[n]) begin
            failures++;
            $display("FAIL decode nibble=%h got %b required %b", n, seg, dec_tab[n]);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_blank_dp();
    int k;
    logic g;
    start(16'h3210, 4'b0100, 4'b0001);
    for (int t = 0; t < 32; t++) begin
      k = t / 8;
      g = (t % 8) < 2;
      assertions += 2;
      if (seg !== ((g || k == 2) ? 7'h7F : dec_tab[k])) begin
        failures++;
        $display("FAIL blank_seg t=%0d got %b required %b", t, seg, (g || k == 2) ? 7'h7F : dec_tab[k]);
      end
      if (dp !== ((!g && k == 0) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL blank_dp t=%0d got %b required %b", t, dp, (!g && k == 0) ? 1'b0 : 1'b1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_load();
    start(16'h3210, 4'b0000, 4'b0000);
    repeat (11) @(negedge clk);
    data_in = 16'h0050;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    assertions++;
    if (seg !== 7'b1001111 || an !== 4'b1101) begin
      failures++;
      $display("FAIL mid_load_edge got seg=%b an=%b required 1001111 1101", seg, an);
    end
    @(negedge clk);
    assertions++;
    if (seg !== 7'b0100100 || an !== 4'b1101) begin
      failures++;
      $display("FAIL mid_load_next got seg=%b an=%b required 0100100 1101", seg, an);
    end
  endtask

  task automatic test_mid_reset();
    start(16'h3210, 4'b0000, 4'b0000);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    assertions++;
    if (an !== 4'b1111 || seg !== 7'h7F || scan_idx !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got an=%b seg=%b idx=%0d required 1111 1111111 0", an, seg, scan_idx);
    end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      assertions++;
      if (an !== (t < 2 ? 4'b1111 : 4'b1110) || seg !== 7'h7F || scan_idx !== 2'd0) begin
        failures++;
        $display("FAIL mid_reset_restart t=%0d got an=%b seg=%b idx=%0d required %b 1111111 0", t, an, seg, scan_idx, t < 2 ? 4'b1111 : 4'b1110);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_blank_dp();
    test_mid_load();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
